// File: rtl/conv_window_scheduler_if.sv
// Signal bundle between the convolution window scheduler, its pixel memory
// read port and the convolution engine. The scheduler side is the master.
interface conv_window_scheduler_if #(
  parameter int IMG_SIZE  = 7,
  parameter int KER_SIZE  = 3,
  parameter int WIDTH_BIT = 8,
  parameter int IDX_W     = $clog2(IMG_SIZE),
  parameter int NW        = IMG_SIZE - KER_SIZE + 1,
  parameter int CNT_W     = $clog2(NW * NW + 1)
);
  logic                                   start;
  logic                                   busy;
  logic                                   done;
  logic                                   pix_rd_en;
  logic [IDX_W-1:0]                       pix_row;
  logic [IDX_W-1:0]                       pix_col;
  logic [WIDTH_BIT-1:0]                   pix_rdata;
  logic                                   win_valid;
  logic                                   win_ready;
  logic [KER_SIZE*KER_SIZE*WIDTH_BIT-1:0] win_data;
  logic [IDX_W-1:0]                       win_row;
  logic [IDX_W-1:0]                       win_col;
  logic                                   eng_done;
  logic [CNT_W-1:0]                       win_count;

  modport master (
    input  start, pix_rdata, win_ready, eng_done,
    output busy, done, pix_rd_en, pix_row, pix_col,
    output win_valid, win_data, win_row, win_col, win_count
  );

  modport slave (
    output start, pix_rdata, win_ready, eng_done,
    input  busy, done, pix_rd_en, pix_row, pix_col,
    input  win_valid, win_data, win_row, win_col, win_count
  );
endinterface

// File: rtl/conv_window_scheduler.sv
// Start/done controlled scheduler that walks every KER_SIZE x KER_SIZE window
// origin of an IMG_SIZE x IMG_SIZE image in raster order, fetches the window
// pixels from a 1-cycle-latency memory, presents the packed window to the
// engine over valid/ready and waits for the engine's completion pulse.
// All outputs are registered: each output flop is loaded from the value that
// corresponds to the next state.
module conv_window_scheduler #(
  parameter int IMG_SIZE  = 7,
  parameter int KER_SIZE  = 3,
  parameter int WIDTH_BIT = 8,
  parameter int IDX_W     = $clog2(IMG_SIZE)
) (
  input  logic                    clock,
  input  logic                    nreset,
  conv_window_scheduler_if.master bus
);
  localparam int NW    = IMG_SIZE - KER_SIZE + 1;
  localparam int KK    = KER_SIZE * KER_SIZE;
  localparam int CNT_W = $clog2(NW * NW + 1);
  localparam int FC_W  = $clog2(KK + 1);
  localparam int WIN_W = KK * WIDTH_BIT;

  localparam logic [IDX_W-1:0] LAST_ORG = IDX_W'(NW - 1);
  localparam logic [IDX_W-1:0] KER_LAST = IDX_W'(KER_SIZE - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(KK);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [FC_W-1:0]    fetch_cnt_q, fetch_cnt_d;   // FETCH cycle index (read index)
  logic [IDX_W-1:0]   kr_q, kr_d, kc_q, kc_d;     // kernel offset of the read in flight
  logic [IDX_W-1:0]   win_row_q, win_row_d, win_col_q, win_col_d;
  logic [CNT_W-1:0]   win_count_q, win_count_d;
  logic [WIN_W-1:0]   win_data_q, win_data_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               win_valid_q, win_valid_d, pix_rd_en_q, pix_rd_en_d;
  logic [IDX_W-1:0]   pix_row_q, pix_row_d, pix_col_q, pix_col_d;
  logic [FC_W-1:0]    cap_idx_s;                  // slot receiving this cycle's rdata

  // Next-state, counter and datapath logic; registered outputs follow state_d.
  always_comb begin
    state_d     = state_q;
    fetch_cnt_d = fetch_cnt_q;
    kr_d        = kr_q;
    kc_d        = kc_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    win_count_d = win_count_q;
    win_data_d  = win_data_q;
    cap_idx_s   = fetch_cnt_q - FC_W'(1);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d     = S_FETCH;
          fetch_cnt_d = '0;
          kr_d        = '0;
          kc_d        = '0;
          win_row_d   = '0;
          win_col_d   = '0;
          win_count_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        // Read k returns one cycle later, so slot k is written at index k+1;
        // the flat slot number equals the raster read index.
        if (fetch_cnt_q != '0) begin
          win_data_d[int'(cap_idx_s) * WIDTH_BIT +: WIDTH_BIT] = bus.pix_rdata;
        end else begin
          win_data_d = win_data_q;
        end
        if (fetch_cnt_q == FC_LAST) begin
          state_d = S_ISSUE;
        end else begin
          fetch_cnt_d = fetch_cnt_q + FC_W'(1);
          if (kc_q == KER_LAST) begin
            kc_d = '0;
            kr_d = kr_q + IDX_W'(1);
          end else begin
            kc_d = kc_q + IDX_W'(1);
          end
        end
      end
      S_ISSUE: begin
        if (bus.win_ready) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (bus.eng_done) begin
          win_count_d = win_count_q + CNT_W'(1);
          if ((win_row_q == LAST_ORG) && (win_col_q == LAST_ORG)) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_FETCH;
            fetch_cnt_d = '0;
            kr_d        = '0;
            kc_d        = '0;
            if (win_col_q == LAST_ORG) begin
              win_col_d = '0;
              win_row_d = win_row_q + IDX_W'(1);
            end else begin
              win_col_d = win_col_q + IDX_W'(1);
            end
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d      = (state_d == S_FETCH) || (state_d == S_ISSUE) || (state_d == S_WAIT);
    done_d      = (state_d == S_DONE);
    win_valid_d = (state_d == S_ISSUE);
    pix_rd_en_d = (state_d == S_FETCH) && (fetch_cnt_d != FC_LAST);
    // Addresses are driven only with a read so they never leave the image.
    if (pix_rd_en_d) begin
      pix_row_d = win_row_d + kr_d;
      pix_col_d = win_col_d + kc_d;
    end else begin
      pix_row_d = '0;
      pix_col_d = '0;
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (nreset) begin
      state_q     <= S_IDLE;
      fetch_cnt_q <= '0;
      kr_q        <= '0;
      kc_q        <= '0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      win_count_q <= '0;
      win_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      win_valid_q <= 1'b0;
      pix_rd_en_q <= 1'b0;
      pix_row_q   <= '0;
      pix_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      fetch_cnt_q <= fetch_cnt_d;
      kr_q        <= kr_d;
      kc_q        <= kc_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      win_count_q <= win_count_d;
      win_data_q  <= win_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      win_valid_q <= win_valid_d;
      pix_rd_en_q <= pix_rd_en_d;
      pix_row_q   <= pix_row_d;
      pix_col_q   <= pix_col_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pix_rd_en = pix_rd_en_q;
  assign bus.pix_row   = pix_row_q;
  assign bus.pix_col   = pix_col_q;
  assign bus.win_valid = win_valid_q;
  assign bus.win_data  = win_data_q;
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;
  assign bus.win_count = win_count_q;
endmodule

// File: doc/conv_window_scheduler.md
Name: conv_window_scheduler

Overview:
- Sequences a KER_SIZE x KER_SIZE convolution engine over an IMG_SIZE x IMG_SIZE pixel memory, stride 1, raster order (row-major over window origins).
- For each window origin it fetches the pixels from a 1-cycle-latency read port and packs them into a flat window bus.
- It hands the window to the engine over a valid/ready handshake, then waits for the engine's completion pulse.
- It replaces free-running window-index counters with a start/done controlled scheduler that produces tagged output.

Parameters:
- IMG_SIZE, 7: input image side length.
- KER_SIZE, 3: kernel side length; must be <= IMG_SIZE.
- WIDTH_BIT, 8: pixel width in bits.
- IDX_W, $clog2(IMG_SIZE): width of row/column indices (derived).

Ports:
- clock  in  1  single clock, rising edge.
- nreset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a full image pass.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last window completes.
- pix_rd_en  out  1  pixel memory read strobe.
- pix_row  out  IDX_W  pixel read row address.
- pix_col  out  IDX_W  pixel read column address.
- pix_rdata  in  WIDTH_BIT  read data, valid exactly 1 cycle after pix_rd_en.
- win_valid  out  1  window bus valid.
- win_ready  in  1  engine accepts window.
- win_data  out  KER_SIZE*KER_SIZE*WIDTH_BIT  element [kr][kc] at bits (kr*KER_SIZE+kc)*WIDTH_BIT +: WIDTH_BIT.
- win_row  out  IDX_W  origin row of the current window.
- win_col  out  IDX_W  origin column of the current window.
- eng_done  in  1  engine finished the accepted window.
- win_count  out  $clog2(NW*NW+1)  windows completed this pass; NW = IMG_SIZE-KER_SIZE+1.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, internal counters 0, win_data register cleared.
- States: IDLE, FETCH, ISSUE, WAIT, DONE.
- IDLE:
  - start=1 -> FETCH, with origin (0,0) and win_count=0.
  - busy is asserted from the next cycle.
- FETCH:
  - Lasts exactly KER_SIZE*KER_SIZE+1 cycles.
  - In its first KER_SIZE*KER_SIZE cycles it issues pix_rd_en=1 with pix_row=win_row+kr and pix_col=win_col+kc, kc incrementing fastest.
  - pix_rdata is captured into slot (kr,kc) one cycle after its read.
  - pix_rd_en=0 on the final cycle; the state then goes to ISSUE.
- ISSUE:
  - win_valid=1, with win_data, win_row and win_col held stable until handshake.
  - On win_valid & win_ready, win_valid drops the next cycle -> WAIT.
  - win_ready has no effect outside ISSUE.
- WAIT:
  - Holds until eng_done=1; then win_count increments.
  - If the origin is (NW-1,NW-1) -> DONE.
  - Otherwise the origin advances: col+1, or wraps col to 0 with row+1 when col=NW-1 -> FETCH.
  - An eng_done asserted in any other state is ignored.
- DONE: done=1 and busy=0 for exactly one cycle -> IDLE; win_count holds until the next start.
- Start is ignored when not in IDLE, including in DONE.
- Reset mid-operation: next cycle is IDLE with all outputs at reset values. No partial window is presented.
- Earliest timing: start at cycle T -> first pix_rd_en at T+1 -> win_valid at T+KER_SIZE*KER_SIZE+2.
- Per-window minimum period is KER_SIZE*KER_SIZE+3 cycles (FETCH + ISSUE + WAIT, with win_ready and eng_done both immediate).
- Indices never exceed IMG_SIZE-1; no out-of-range read is ever issued.
- Degenerate case KER_SIZE=IMG_SIZE: a single window at (0,0).

Test Plan:
- Reset/idle: hold nreset 3 cycles, then idle 5 cycles with start=0 -> all outputs 0, no pix_rd_en.
- Single window data: memory model p[r][c]=r*7+c, win_ready=1, eng_done one cycle after handshake.
  - First win_data is 0,1,2,7,8,9,14,15,16 with win_row=0, win_col=0.
  - win_valid rises exactly 11 cycles after start.
- Full pass:
  - 25 windows are presented.
  - The origin sequence wraps from (0,4) to (1,0).
  - The last window is (4,4) with data 32,33,34,39,40,41,46,47,48.
  - A done pulse follows the last window; win_count=25; total time 25*12+1 cycles after start (12-cycle window period + the DONE cycle).
- Backpressure: win_ready held low 6 cycles, plus eng_done delayed 4 cycles -> win_valid/win_data stable throughout, no extra reads, counts unchanged otherwise.
- Spurious inputs:
  - start pulsed during FETCH and WAIT -> ignored.
  - eng_done pulsed during FETCH -> no advance.
  - start in the DONE cycle -> ignored, busy stays 0.
- Reset mid-pass: assert nreset during the ISSUE state of window 7 -> IDLE next cycle with outputs 0; a new start restarts at (0,0) with win_count=0.
